// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, SRAM read port, hold buffer, pending redirect.
// Optional misaligned-fetch detection when FETCH_ADEL_EN is defined.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
`ifdef FETCH_ADEL_EN
    output logic        fetch_adel,
`endif
    output logic [31:0] id_inst
);

    localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

    logic        pc_stop;
    logic        id_stop;
    logic        br_e;
    logic [31:0] br_addr;

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        redir_v_q, redir_v_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] live_inst;
    logic [31:0] next_pc;

    logic        unused_stall;
    assign unused_stall = ^stall[5:2];

    assign pc_stop = stall[0];
    assign id_stop = stall[1];
    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    assign next_pc = br_e      ? br_addr      :
                     redir_v_q ? redir_addr_q :
                     pc_q + 32'd4;

`ifdef FETCH_ADEL_EN
    logic adel_q;
    assign fetch_adel   = ce_q & (pc_q[1:0] != 2'b00);
    assign inst_sram_en = ce_q & ~fetch_adel;
    // A refused fetch returns a NOP in the data cycle.
    assign live_inst    = adel_q ? 32'h0 : inst_sram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= fetch_adel;
        end
    end
`else
    assign inst_sram_en = ce_q;
    assign live_inst    = inst_sram_rdata;
`endif

    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        redir_v_d    = redir_v_q;
        redir_addr_d = redir_addr_q;
        hold_v_d     = hold_v_q;
        hold_inst_d  = hold_inst_q;

        if (!pc_stop) begin
            pc_d      = next_pc;
            ce_d      = 1'b1;
            redir_v_d = 1'b0;
        end else if (br_e) begin
            redir_v_d    = 1'b1;
            redir_addr_d = br_addr;
        end

        // Only the first word seen during an ID stall belongs to ID's PC.
        if (!id_stop) begin
            hold_v_d = 1'b0;
        end else if (!hold_v_q) begin
            hold_v_d    = 1'b1;
            hold_inst_d = live_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RST_PC;
            ce_q         <= 1'b0;
            redir_v_q    <= 1'b0;
            redir_addr_q <= 32'h0;
            hold_v_q     <= 1'b0;
            hold_inst_q  <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            redir_v_q    <= redir_v_d;
            redir_addr_q <= redir_addr_d;
            hold_v_q     <= hold_v_d;
            hold_inst_q  <= hold_inst_d;
        end
    end

    assign if_to_id_bus    = {ce_q, pc_q};
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0;
    assign id_inst         = hold_v_q ? hold_inst_q : live_inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch (default build).
`timescale 1ns/1ps
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_inst;

    int checks;
    int failures;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 6'd0;
        br_bus = 33'd0;
        inst_sram_rdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (inst_sram_en !== 1'b0) begin
            $display("FAIL reset_en got=%b exp=0", inst_sram_en);
            failures++;
        end
        checks++;
        if (inst_sram_addr !== 32'hBFBF_FFFC) begin
            $display("FAIL reset_pc got=%h exp=bfbffffc", inst_sram_addr);
            failures++;
        end
        checks++;
        if (id_inst !== 32'hA5A5_A5A5) begin
            $display("FAIL reset_id_inst got=%h exp=a5a5a5a5", id_inst);
            failures++;
        end
        checks++;
        if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'h0) begin
            $display("FAIL reset_wr got=%h/%h exp=0/0", inst_sram_wen, inst_sram_wdata);
            failures++;
        end
    endtask

    task automatic test_release();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hBFC0_0000;
        exp_pc[1] = 32'hBFC0_0004;
        exp_pc[2] = 32'hBFC0_0008;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_sram_addr !== exp_pc[i] || inst_sram_en !== 1'b1) begin
                $display("FAIL release_%0d got=%h en=%b exp=%h en=1",
                         i, inst_sram_addr, inst_sram_en, exp_pc[i]);
                failures++;
            end
        end
        checks++;
        if (if_to_id_bus !== {1'b1, 32'hBFC0_0008}) begin
            $display("FAIL release_bus got=%h exp=1bfc00008", if_to_id_bus);
            failures++;
        end
    endtask

    task automatic test_branch();
        br_bus = {1'b1, 32'hBFC0_0100};
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0100) begin
            $display("FAIL branch_tgt got=%h exp=bfc00100", inst_sram_addr);
            failures++;
        end
        br_bus = 33'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0104) begin
            $display("FAIL branch_seq got=%h exp=bfc00104", inst_sram_addr);
            failures++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd [3];
        rd[0] = 32'h1111_1111;
        rd[1] = 32'h2222_2222;
        rd[2] = 32'h3333_3333;
        stall = 6'b000011;
        for (int i = 0; i < 3; i++) begin
            inst_sram_rdata = rd[i];
            tick();
            checks++;
            if (id_inst !== 32'h1111_1111 || inst_sram_addr !== 32'hBFC0_0104) begin
                $display("FAIL hold_%0d got=%h pc=%h exp=11111111 pc=bfc00104",
                         i, id_inst, inst_sram_addr);
                failures++;
            end
        end
        stall = 6'd0;
        tick();
        checks++;
        if (id_inst !== 32'h3333_3333 || inst_sram_addr !== 32'hBFC0_0108) begin
            $display("FAIL hold_release got=%h pc=%h exp=33333333 pc=bfc00108",
                     id_inst, inst_sram_addr);
            failures++;
        end
        inst_sram_rdata = 32'h4444_4444;
        #1;
        checks++;
        if (id_inst !== 32'h4444_4444) begin
            $display("FAIL hold_live got=%h exp=44444444", id_inst);
            failures++;
        end
    endtask

    task automatic test_redirect();
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        tick();
        br_bus = 33'd0;
        tick();
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0108) begin
            $display("FAIL redir_hold got=%h exp=bfc00108", inst_sram_addr);
            failures++;
        end
        stall = 6'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0200) begin
            $display("FAIL redir_take got=%h exp=bfc00200", inst_sram_addr);
            failures++;
        end
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0204) begin
            $display("FAIL redir_clear got=%h exp=bfc00204", inst_sram_addr);
            failures++;
        end
    endtask

    task automatic test_priority();
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        tick();
        br_bus = 33'd0;
        tick();
        stall = 6'd0;
        br_bus = {1'b1, 32'hBFC0_0300};
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0300) begin
            $display("FAIL prio_live got=%h exp=bfc00300", inst_sram_addr);
            failures++;
        end
        br_bus = 33'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0304) begin
            $display("FAIL prio_next got=%h exp=bfc00304", inst_sram_addr);
            failures++;
        end
    endtask

    task automatic test_overwrite();
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0400};
        tick();
        br_bus = {1'b1, 32'hBFC0_0500};
        tick();
        br_bus = 33'd0;
        stall = 6'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0500) begin
            $display("FAIL redir_overwrite got=%h exp=bfc00500", inst_sram_addr);
            failures++;
        end
    endtask

    task automatic test_wrap();
        br_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        br_bus = 33'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'h0000_0000) begin
            $display("FAIL pc_wrap got=%h exp=00000000", inst_sram_addr);
            failures++;
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 6'b000011;
        br_bus = {1'b1, 32'hBFC0_0600};
        inst_sram_rdata = 32'h7777_7777;
        tick();
        br_bus = 33'd0;
        rst = 1'b1;
        tick();
        inst_sram_rdata = 32'h8888_8888;
        #1;
        checks++;
        if (id_inst !== 32'h8888_8888 || inst_sram_en !== 1'b0) begin
            $display("FAIL rst_mid got=%h en=%b exp=88888888 en=0", id_inst, inst_sram_en);
            failures++;
        end
        rst = 1'b0;
        stall = 6'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0000) begin
            $display("FAIL rst_drop got=%h exp=bfc00000", inst_sram_addr);
            failures++;
        end
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0004) begin
            $display("FAIL rst_seq got=%h exp=bfc00004", inst_sram_addr);
            failures++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_release();
        test_branch();
        test_hold();
        test_redirect();
        test_priority();
        test_overwrite();
        test_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
